// File: rtl/genius_pkg.sv
// ---------------------------------------------------------------------------
// genius_pkg
// Shared types for the colour-sequence game.
//   colour_t      : 2-bit colour encoding used on C_IN, RD_COLOR and VGA.
//   play_state_t  : playback FSM states of seq_playback_ctrl.
//   MAX_LEN_DEF   : default depth of the sequence store.
// ---------------------------------------------------------------------------
package genius_pkg;

  typedef enum logic [1:0] {
    BLUE   = 2'b00,
    GREEN  = 2'b01,
    RED    = 2'b10,
    YELLOW = 2'b11
  } colour_t;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP,
    FIN
  } play_state_t;

  localparam int MAX_LEN_DEF = 16;

endpackage

// File: rtl/seq_playback_ctrl_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
// Down-counter used to time fixed-length intervals.
//   CLK, RESET : clock, synchronous active-high reset
//   load_i     : reload the counter with value_i (takes priority over en_i)
//   value_i    : interval length in cycles (>=1)
//   en_i       : count enable
//   expire_o   : high in the last cycle of the interval (count==1 with en_i)
// ---------------------------------------------------------------------------
module tick_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with <= only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/seq_playback_ctrl.sv
// ---------------------------------------------------------------------------
// seq_playback_ctrl
// Stores the game's colour sequence and plays it back to the VGA colour path
// with fixed on/off timing.
//   CLK, RESET : clock, synchronous active-high reset
//   CLR        : clear the sequence; aborts playback
//   APPEND     : pulse, store C_IN at index LEN
//   C_IN       : colour to append
//   PLAY       : pulse, play entries 0..LEN-1
//   RD_IDX     : read index; RD_COLOR = store[RD_IDX], 0 beyond LEN
//   LEN, FULL  : current length, LEN==MAX_LEN
//   BUSY       : playback in progress (SHOW/GAP/FIN)
//   DONE       : pulse in the cycle after the last gap
//   VGA        : colour being shown (held through the gap)
//   VGA_FLAG   : high while a colour is shown
//   ERR        : pulse in the cycle after a rejected command
// ---------------------------------------------------------------------------
module seq_playback_ctrl
  import genius_pkg::*;
#(
  parameter  int MAX_LEN   = MAX_LEN_DEF,
  parameter  int ON_TICKS  = 50,
  parameter  int OFF_TICKS = 10,
  localparam int IDX_W     = $clog2(MAX_LEN),
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic             APPEND,
  input  logic [1:0]       C_IN,
  input  logic             PLAY,
  input  logic [IDX_W-1:0] RD_IDX,
  output logic [1:0]       RD_COLOR,
  output logic [LEN_W-1:0] LEN,
  output logic             FULL,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       VGA,
  output logic             VGA_FLAG,
  output logic             ERR
);

  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  play_state_t      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  colour_t          vga_q, vga_d;
  logic             vga_flag_q, vga_flag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic             busy, full, last_entry;
  logic             t_load, t_en, t_expire;
  logic [TW-1:0]    t_value;

  colour_t          store [MAX_LEN];

  assign busy       = (state_q != IDLE);
  assign full       = (len_q == LEN_W'(MAX_LEN));
  assign last_entry = (LEN_W'(idx_q) == len_q - LEN_W'(1));

  // Every SHOW/GAP entry reloads the timer so each interval is exact.
  assign t_en    = (state_q == SHOW) || (state_q == GAP);
  assign t_load  = (state_d != state_q) && ((state_d == SHOW) || (state_d == GAP));
  assign t_value = (state_d == GAP) ? TW'(OFF_TICKS) : TW'(ON_TICKS);

  tick_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load_i   (t_load),
    .value_i  (t_value),
    .en_i     (t_en),
    .expire_o (t_expire)
  );

  // State register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      vga_q      <= BLUE;
      vga_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      vga_q      <= vga_d;
      vga_flag_q <= vga_flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the store is not reset; its contents are meaningless until written
  // and RD_COLOR masks entries at or beyond LEN.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      store[len_q[IDX_W-1:0]] <= colour_t'(C_IN);
    end
  end

  // Next-state logic: CLR > APPEND > PLAY in IDLE, CLR aborts when busy.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    if (busy && CLR) begin
      state_d = IDLE;
      len_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (CLR) begin
            len_d = '0;
          end else if (APPEND) begin
            if (!full) begin
              wr_en = 1'b1;
              len_d = len_q + LEN_W'(1);
            end
          end else if (PLAY && len_q != '0) begin
            state_d = SHOW;
            idx_d   = '0;
          end
        end
        SHOW: if (t_expire) state_d = GAP;
        GAP: begin
          if (t_expire) begin
            if (last_entry) begin
              state_d = FIN;
            end else begin
              state_d = SHOW;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: values the output registers take on the next edge.
  always_comb begin
    if (CLR) begin
      err_d = 1'b0;
    end else if (busy) begin
      err_d = APPEND || PLAY;
    end else if (APPEND) begin
      err_d = full;
    end else begin
      err_d = PLAY && (len_q == '0);
    end
    done_d     = (state_d == FIN);
    vga_flag_d = (state_d == SHOW);
    vga_d      = (state_d == SHOW) ? store[idx_d] : vga_q;
  end

  assign RD_COLOR = (LEN_W'(RD_IDX) < len_q) ? store[RD_IDX] : BLUE;
  assign LEN      = len_q;
  assign FULL     = full;
  assign BUSY     = busy;
  assign DONE     = done_q;
  assign VGA      = vga_q;
  assign VGA_FLAG = vga_flag_q;
  assign ERR      = err_q;

endmodule

// File: doc/seq_playback_ctrl.md
Name: seq_playback_ctrl

Overview:
- Owns the game's colour-sequence store: up to MAX_LEN 2-bit colours, appended one per round.
- Plays the stored sequence back to the VGA colour path with fixed on/off timing from an internal tick counter.
- Replaces the per-index SEQ case chains and the external display timer (START_1/END_1) in the game controller, which now issues only APPEND/PLAY/CLR and reads colours for comparison.

Parameters:
MAX_LEN, 16, maximum sequence length (entries)
ON_TICKS, 50, cycles a colour is shown with VGA_FLAG=1 (>=1)
OFF_TICKS, 10, blank cycles after each colour, VGA_FLAG=0 (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
CLR  in  1  clear sequence (LEN<=0); aborts playback
APPEND  in  1  one-cycle pulse: store C_IN at index LEN, LEN<=LEN+1
C_IN  in  2  colour to append (genius_pkg encoding)
PLAY  in  1  one-cycle pulse: start playback of entries 0..LEN-1
RD_IDX  in  4  read index for comparison
RD_COLOR  out  2  combinational store[RD_IDX]; 0 if RD_IDX>=LEN
LEN  out  5  current sequence length, 0..MAX_LEN
FULL  out  1  LEN==MAX_LEN
BUSY  out  1  state != IDLE
DONE  out  1  one-cycle pulse at end of playback
VGA  out  2  colour being shown
VGA_FLAG  out  1  high while a colour is shown
ERR  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset: state IDLE, LEN=0, play index 0, tick counter 0, VGA=0, VGA_FLAG=0, DONE=0, ERR=0, BUSY=0. Store contents are don't-care.
- FSM states: IDLE, SHOW, GAP, FIN.
- IDLE command priority, one command honoured per cycle: CLR > APPEND > PLAY. Lower-priority commands asserted in the same cycle are dropped silently, with no ERR.
- APPEND with FULL=1: no write, LEN unchanged, ERR pulse next cycle.
- APPEND with FULL=0: write at edge k; LEN updated and RD_COLOR valid from cycle k+1.
- PLAY with LEN=0: stay IDLE, ERR pulse.
- PLAY with LEN>0, sampled at edge k: SHOW from cycle k+1, index=0, VGA=store[0], VGA_FLAG=1.
- SHOW: lasts exactly ON_TICKS cycles, then GAP.
- GAP: lasts exactly OFF_TICKS cycles. VGA_FLAG=0; VGA holds the last colour.
- End of GAP: if index==LEN-1, go to FIN; else index++ and return to SHOW.
- FIN: one cycle, DONE=1, then IDLE.
- PLAY edge to DONE cycle: LEN*(ON_TICKS+OFF_TICKS)+1 cycles.
- BUSY=1 in SHOW, GAP and FIN.
- While BUSY:
  - APPEND and PLAY are ignored, store and LEN unchanged, ERR pulse.
  - CLR forces IDLE next cycle with LEN=0, VGA_FLAG=0, and no DONE.
- RESET mid-playback: same as reset, with no DONE.
- Tick counter reloads on every state entry, so the timing is exact.
- LEN is sampled at PLAY; it cannot change during playback.
- Arithmetic: LEN is 5 bits and saturates at MAX_LEN through the FULL check. Index and counters never wrap.
- All outputs are registered except RD_COLOR, FULL and BUSY, which decode combinationally from registers.

Decomposition:
- Shared package genius_pkg:
  - colour_t (2 bits): BLUE=2'b00, GREEN=2'b01, RED=2'b10, YELLOW=2'b11.
  - MAX_LEN default.
  - Playback state enum: IDLE, SHOW, GAP, FIN.
- Store: a plain register array indexed by LEN/index/RD_IDX, replacing the hand-written slice cases.
- One sub-module, tick_timer:
  - Inputs: LOAD with value, EN.
  - Output: EXPIRE, asserted when the count reaches 1 with EN.
  - Used for both SHOW and GAP durations; the controller's input timeout may reuse it later.

Test Plan:
1. Reset, then APPEND C_IN=RED,GREEN,YELLOW on 3 cycles -> LEN=3; RD_IDX=0,1,2 give 10,01,11; RD_IDX=3 gives 00.
2. With ON_TICKS=4, OFF_TICKS=2 and LEN=3, pulse PLAY at cycle 0:
   - VGA_FLAG high cycles 1-4 (VGA=10), 7-10 (01), 13-16 (11);
   - DONE at cycle 19;
   - BUSY low at cycle 20.
3. Fill 16 entries, then APPEND -> ERR pulse, LEN stays 16, FULL=1, store[15] unchanged.
4. PLAY with LEN=0 -> ERR pulse, BUSY stays 0, no VGA_FLAG.
5. During playback:
   - APPEND and PLAY each give an ERR pulse, LEN unchanged, timing unchanged;
   - then CLR at cycle 8 -> IDLE at cycle 9, LEN=0, VGA_FLAG=0, no DONE.
6. CLR+APPEND+PLAY same cycle in IDLE -> LEN=0, no playback, no ERR. RESET mid-SHOW -> all outputs at reset values next cycle.
